// File: rtl/gpio_bank.sv
// GPIO bank on the PicoBlaze port bus: direction, synchronised input, edge-detect IRQ.
// Optional input debounce filter enabled by defining GPIO_DEBOUNCE_EN.
module gpio_bank #(
    parameter logic [7:0]  BASE_ADDR   = 8'h10,
    parameter int unsigned WIDTH       = 8,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned DB_CYCLES   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [7:0]       address,
    input  logic [7:0]       value_in,
    input  logic             wen,
    input  logic             ren,
    output logic [7:0]       data_out,
    output logic             hit,
    input  logic [WIDTH-1:0] pins_in,
    output logic [WIDTH-1:0] pins_out,
    output logic [WIDTH-1:0] pins_oe,
    output logic             irq,
    input  logic             irq_ack
);

    localparam logic [7:0] OFS_OUT    = 8'd0;
    localparam logic [7:0] OFS_DIR    = 8'd1;
    localparam logic [7:0] OFS_IN     = 8'd2;
    localparam logic [7:0] OFS_STATUS = 8'd3;
    localparam logic [7:0] OFS_MASK   = 8'd4;
    localparam logic [7:0] OFS_EDGE   = 8'd5;

    logic [7:0]       offset;
    logic [WIDTH-1:0] wdata;
    logic             wr_out, wr_dir, wr_status, wr_mask, wr_edge;

    logic [WIDTH-1:0] out_q, dir_q, status_q, mask_q, edge_sel_q;
    logic [WIDTH-1:0] sync_q [SYNC_STAGES];
    logic [WIDTH-1:0] synced, filt, prev_q;
    logic [WIDTH-1:0] edge_c, clr_c;

    // ren carries no side effect; upper value_in bits are dropped when WIDTH < 8
    logic unused_cfg;
    assign unused_cfg = ^{ren, value_in, DB_CYCLES};

    // Address decode over BASE_ADDR..BASE_ADDR+5, computed in 9 bits to avoid wrap
    assign offset = 8'(address - BASE_ADDR);
    assign hit    = ({1'b0, address} >= {1'b0, BASE_ADDR}) &&
                    ({1'b0, address} <= ({1'b0, BASE_ADDR} + 9'd5));
    assign wdata  = value_in[WIDTH-1:0];

    assign wr_out    = wen && hit && (offset == OFS_OUT);
    assign wr_dir    = wen && hit && (offset == OFS_DIR);
    assign wr_status = wen && hit && (offset == OFS_STATUS);
    assign wr_mask   = wen && hit && (offset == OFS_MASK);
    assign wr_edge   = wen && hit && (offset == OFS_EDGE);

    // Pad input synchroniser
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= '0;
            end
        end else begin
            sync_q[0] <= pins_in;
            for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    assign synced = sync_q[SYNC_STAGES-1];

`ifdef GPIO_DEBOUNCE_EN
    localparam logic [7:0] DB_LAST = 8'(DB_CYCLES - 1);

    logic [7:0]       db_cnt [WIDTH];
    logic [WIDTH-1:0] filt_q;

    // Filtered bit follows synced only after DB_CYCLES consecutive disagreeing clocks
    always_ff @(posedge clk) begin
        if (rst) begin
            filt_q <= '0;
            for (int unsigned i = 0; i < WIDTH; i++) begin
                db_cnt[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < WIDTH; i++) begin
                if (synced[i] == filt_q[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] >= DB_LAST) begin
                    filt_q[i] <= synced[i];
                    db_cnt[i] <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + 8'd1;
                end
            end
        end
    end

    assign filt = filt_q;
`else
    assign filt = synced;
`endif

    // Per-pin edge select and STATUS clear sources
    always_comb begin
        edge_c = (filt & ~prev_q & ~edge_sel_q) | (~filt & prev_q & edge_sel_q);
        clr_c  = '0;
        if (wr_status) begin
            clr_c = clr_c | wdata;
        end
        if (irq_ack) begin
            clr_c = clr_c | mask_q;
        end
    end

    // Control registers, edge history, sticky status and irq; a new edge beats a clear
    always_ff @(posedge clk) begin
        if (rst) begin
            out_q      <= '0;
            dir_q      <= '0;
            status_q   <= '0;
            mask_q     <= '0;
            edge_sel_q <= '0;
            prev_q     <= '0;
            irq        <= 1'b0;
        end else begin
            if (wr_out)  out_q      <= wdata;
            if (wr_dir)  dir_q      <= wdata;
            if (wr_mask) mask_q     <= wdata;
            if (wr_edge) edge_sel_q <= wdata;
            prev_q   <= filt;
            status_q <= (status_q & ~clr_c) | edge_c;
            irq      <= |(status_q & mask_q);
        end
    end

    assign pins_out = out_q;
    assign pins_oe  = dir_q;

    // Read mux; zero when not addressed so banks can be OR-ed together
    always_comb begin
        data_out = 8'h00;
        if (hit) begin
            case (offset)
                OFS_OUT:    data_out = 8'(out_q);
                OFS_DIR:    data_out = 8'(dir_q);
                OFS_IN:     data_out = 8'(filt);
                OFS_STATUS: data_out = 8'(status_q);
                OFS_MASK:   data_out = 8'(mask_q);
                OFS_EDGE:   data_out = 8'(edge_sel_q);
                default:    data_out = 8'h00;
            endcase
        end
    end

endmodule

// File: tb/tb_gpio_bank.sv
// Directed self-checking bench for gpio_bank at default parameters.
module tb_gpio_bank;

`ifdef GPIO_DEBOUNCE_EN
    localparam int LAT = 2 + 16;
`else
    localparam int LAT = 2;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] address, value_in;
    logic       wen, ren, irq_ack;
    logic [7:0] data_out;
    logic       hit;
    logic [7:0] pins_in, pins_out, pins_oe;
    logic       irq;

    int n_vec = 0;
    int n_err = 0;

    gpio_bank dut (
        .clk      (clk),
        .rst      (rst),
        .address  (address),
        .value_in (value_in),
        .wen      (wen),
        .ren      (ren),
        .data_out (data_out),
        .hit      (hit),
        .pins_in  (pins_in),
        .pins_out (pins_out),
        .pins_oe  (pins_oe),
        .irq      (irq),
        .irq_ack  (irq_ack)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [7:0] a, input logic [7:0] d);
        address  = a;
        value_in = d;
        wen      = 1'b1;
        tick();
        wen      = 1'b0;
    endtask

    task automatic rd(input string tag, input logic [7:0] a, input logic [7:0] exp);
        address = a;
        ren     = 1'b1;
        #1;
        chk(tag, data_out, exp);
        ren     = 1'b0;
    endtask

    initial begin
        rst = 1'b1; address = 8'h00; value_in = 8'h00;
        wen = 1'b0; ren = 1'b0; irq_ack = 1'b0; pins_in = 8'h00;
        tick();
        tick();
        chk("rst_pins_out", pins_out, 8'h00);
        chk("rst_irq", irq, 1'b0);
        rst = 1'b0;
        tick();
        chk("post_rst_oe", pins_oe, 8'h00);
        rd("post_rst_status", 8'h13, 8'h00);

        // register access and decode
        wr(8'h10, 8'hA5);
        wr(8'h11, 8'h0F);
        chk("pins_out", pins_out, 8'hA5);
        chk("pins_oe", pins_oe, 8'h0F);
        rd("rd_out", 8'h10, 8'hA5);
        chk("hit_in", hit, 1'b1);
        rd("rd_dir", 8'h11, 8'h0F);
        rd("rd_miss", 8'h00, 8'h00);
        chk("hit_miss", hit, 1'b0);
        address = 8'h16; #1;
        chk("hit_above", hit, 1'b0);
        address = 8'h15; #1;
        chk("hit_top", hit, 1'b1);
        wr(8'h12, 8'hFF);
        rd("in_ro", 8'h12, 8'h00);

        // input latency and rising-edge status
        pins_in = 8'h3C;
        repeat (LAT - 1) tick();
        rd("in_early", 8'h12, 8'h00);
        tick();
        rd("in_lat", 8'h12, 8'h3C);
        rd("status_pre", 8'h13, 8'h00);
        tick();
        rd("status_rise", 8'h13, 8'h3C);
        chk("irq_unmasked", irq, 1'b0);

        // masked irq and acknowledge
        wr(8'h13, 8'hFF);
        rd("w1c_all", 8'h13, 8'h00);
        wr(8'h14, 8'h04);
        pins_in = 8'h38;
        repeat (LAT + 2) tick();
        rd("fall_ignored", 8'h13, 8'h00);
        pins_in = 8'h7C;
        repeat (LAT) tick();
        rd("in_7c", 8'h12, 8'h7C);
        chk("irq_idle", irq, 1'b0);
        tick();
        rd("status_44", 8'h13, 8'h44);
        chk("irq_lag", irq, 1'b0);
        tick();
        chk("irq_set", irq, 1'b1);
        irq_ack = 1'b1;
        tick();
        irq_ack = 1'b0;
        rd("ack_clear", 8'h13, 8'h40);
        chk("irq_hold", irq, 1'b1);
        tick();
        chk("irq_drop", irq, 1'b0);
        wr(8'h13, 8'h00);
        rd("w0_keep", 8'h13, 8'h40);
        wr(8'h14, 8'h40);
        rd("mask_no_set", 8'h13, 8'h40);
        chk("irq_mask_lag", irq, 1'b0);
        tick();
        chk("irq_mask_raise", irq, 1'b1);
        wr(8'h13, 8'hFF);
        tick();
        chk("irq_after_w1c", irq, 1'b0);

        // falling-edge select and set-wins
        wr(8'h15, 8'h01);
        pins_in = 8'h7D;
        repeat (LAT + 2) tick();
        rd("rise_ignored", 8'h13, 8'h00);
        pins_in = 8'h7C;
        repeat (LAT) tick();
        rd("in_fall", 8'h12, 8'h7C);
        wr(8'h13, 8'h01);
        rd("set_wins", 8'h13, 8'h01);

        // reset mid-operation
        wr(8'h14, 8'h01);
        tick();
        chk("irq_pre_rst", irq, 1'b1);
        wr(8'h10, 8'hFF);
        chk("out_ff", pins_out, 8'hFF);
        rst = 1'b1;
        tick();
        chk("mid_rst_irq", irq, 1'b0);
        chk("mid_rst_out", pins_out, 8'h00);
        chk("mid_rst_oe", pins_oe, 8'h00);
        rd("mid_rst_status", 8'h13, 8'h00);
        rst = 1'b0;
        tick();
        rd("mid_rst_mask", 8'h14, 8'h00);
        rd("mid_rst_edge", 8'h15, 8'h00);

`ifdef GPIO_DEBOUNCE_EN
        pins_in = 8'h00;
        repeat (LAT + 4) tick();
        wr(8'h13, 8'hFF);
        rd("db_clean", 8'h13, 8'h00);
        pins_in = 8'h02;
        repeat (10) tick();
        pins_in = 8'h00;
        repeat (LAT + 4) tick();
        rd("db_glitch_in", 8'h12, 8'h00);
        rd("db_glitch_status", 8'h13, 8'h00);
        pins_in = 8'h02;
        repeat (LAT - 1) tick();
        rd("db_early", 8'h12, 8'h00);
        tick();
        rd("db_in", 8'h12, 8'h02);
        tick();
        rd("db_status", 8'h13, 8'h02);
        repeat (3) tick();
        rd("db_status_hold", 8'h13, 8'h02);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
